// File: rtl/picoctrl_seq_core.sv
// PicoCtrl fetch/execute core: drives the ROM address from the PC, decodes the
// returned word against synchronised c0/c1, and performs register writes or jumps.
module picoctrl_seq_core #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [4:0]  RESET_PC    = 5'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        c0,
    input  logic        c1,
    output logic [4:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [7:0]  reg0_q,
    output logic [7:0]  reg1_q,
    output logic [7:0]  reg2_q,
    output logic [7:0]  reg3_q,
    output logic [3:0]  reg_wr,
    output logic        jump_taken
);

    localparam int unsigned PC_W   = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREG   = 4;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_C0_LO  = 3'b001;
    localparam logic [2:0] COND_C0_HI  = 3'b010;
    localparam logic [2:0] COND_C1_LO  = 3'b011;
    localparam logic [2:0] COND_C1_HI  = 3'b100;
    localparam logic [2:0] ACT_WRITE   = 3'b001;
    localparam logic [2:0] ACT_JUMP    = 3'b010;

    logic [SYNC_STAGES-1:0] c0_sync;
    logic [SYNC_STAGES-1:0] c1_sync;
    logic [PC_W-1:0]        pc;
    logic [DATA_W-1:0]      regs [NREG];

    logic [2:0]        cond_c;
    logic [2:0]        action_c;
    logic [1:0]        sel_c;
    logic [DATA_W-1:0] imm_c;
    logic              cond_true_c;
    logic              do_write_c;
    logic              do_jump_c;
    logic [PC_W-1:0]   pc_next_c;

    assign rom_addr = pc;
    assign reg0_q   = regs[0];
    assign reg1_q   = regs[1];
    assign reg2_q   = regs[2];
    assign reg3_q   = regs[3];

    // Decode; unknown condition codes evaluate false and unknown actions act as nop
    always_comb begin
        cond_c      = rom_data[15:13];
        action_c    = rom_data[12:10];
        sel_c       = rom_data[9:8];
        imm_c       = rom_data[7:0];
        cond_true_c = 1'b0;
        case (cond_c)
            COND_ALWAYS: cond_true_c = 1'b1;
            COND_C0_LO:  cond_true_c = ~c0_sync[SYNC_STAGES-1];
            COND_C0_HI:  cond_true_c = c0_sync[SYNC_STAGES-1];
            COND_C1_LO:  cond_true_c = ~c1_sync[SYNC_STAGES-1];
            COND_C1_HI:  cond_true_c = c1_sync[SYNC_STAGES-1];
            default:     cond_true_c = 1'b0;
        endcase
        do_write_c = cond_true_c && (action_c == ACT_WRITE);
        do_jump_c  = cond_true_c && (action_c == ACT_JUMP);
        pc_next_c  = do_jump_c ? imm_c[PC_W-1:0] : PC_W'(pc + PC_W'(1));
    end

    // PC, register file, pulses and sync chains all advance only when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            reg_wr     <= '0;
            jump_taken <= 1'b0;
            c0_sync    <= '0;
            c1_sync    <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (en) begin
            pc         <= pc_next_c;
            reg_wr     <= do_write_c ? NREG'(NREG'(1) << sel_c) : '0;
            jump_taken <= do_jump_c;
            if (do_write_c) begin
                regs[sel_c] <= imm_c;
            end
            c0_sync[0] <= c0;
            c1_sync[0] <= c1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                c0_sync[i] <= c0_sync[i-1];
                c1_sync[i] <= c1_sync[i-1];
            end
        end else begin
            reg_wr     <= '0;
            jump_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_picoctrl_seq_core.sv
// Bench for picoctrl_seq_core: an instruction-level reference model checked every
// cycle, plus directed literal expectations for reset, wait loop, wrap and en gating.
module tb_picoctrl_seq_core;

    localparam int unsigned SYNC = 2;
    localparam logic [4:0]  RPC  = 5'h00;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        c0    = 1'b0;
    logic        c1    = 1'b0;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  reg0_q, reg1_q, reg2_q, reg3_q;
    logic [3:0]  reg_wr;
    logic        jump_taken;

    logic [15:0] rom [32];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    picoctrl_seq_core #(.SYNC_STAGES(SYNC), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .c0(c0), .c1(c1),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .reg0_q(reg0_q), .reg1_q(reg1_q), .reg2_q(reg2_q), .reg3_q(reg3_q),
        .reg_wr(reg_wr), .jump_taken(jump_taken)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: condition sees the input value sampled SYNC enabled edges earlier
    int unsigned m_pc;
    int unsigned m_reg [4];
    int unsigned m_wr;
    bit          m_jt;
    bit          h0 [$];
    bit          h1 [$];

    always @(posedge clk or negedge rst_n) begin
        int unsigned w, cnd, act, sel, imm;
        bit s0, s1, ok;
        if (!rst_n) begin
            m_pc = RPC;
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_wr = 0;
            m_jt = 0;
            h0.delete();
            h1.delete();
        end else if (en) begin
            w   = rom[m_pc];
            cnd = w / 8192;
            act = (w / 1024) % 8;
            sel = (w / 256) % 4;
            imm = w % 256;
            s0  = (h0.size() >= SYNC) ? h0[h0.size() - SYNC] : 1'b0;
            s1  = (h1.size() >= SYNC) ? h1[h1.size() - SYNC] : 1'b0;
            ok  = (cnd == 0) || (cnd == 1 && !s0) || (cnd == 2 && s0) ||
                  (cnd == 3 && !s1) || (cnd == 4 && s1);
            m_wr = 0;
            m_jt = 0;
            if (ok && act == 1) begin
                m_reg[sel] = imm;
                m_wr = 1 << sel;
                m_pc = (m_pc + 1) % 32;
            end else if (ok && act == 2) begin
                m_pc = imm % 32;
                m_jt = 1;
            end else begin
                m_pc = (m_pc + 1) % 32;
            end
            h0.push_back(c0);
            h1.push_back(c1);
        end else begin
            m_wr = 0;
            m_jt = 0;
        end
    end

    always @(negedge clk) begin
        chk("m_rom_addr", 16'(rom_addr), 16'(m_pc));
        chk("m_reg0", 16'(reg0_q), 16'(m_reg[0]));
        chk("m_reg1", 16'(reg1_q), 16'(m_reg[1]));
        chk("m_reg2", 16'(reg2_q), 16'(m_reg[2]));
        chk("m_reg3", 16'(reg3_q), 16'(m_reg[3]));
        chk("m_reg_wr", 16'(reg_wr), 16'(m_wr));
        chk("m_jump", 16'(jump_taken), 16'(m_jt));
    end

    initial begin
        int k;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2501;   // if c0==0: reg1 = 01
        rom[1] = 16'h8801;   // if c1==1: jump 1 (wait loop)
        rom[2] = 16'h06AA;   // reg2 = AA
        rom[3] = 16'h0755;   // reg3 = 55
        rom[4] = 16'hA81F;   // never-cond jump
        rom[5] = 16'h1CFF;   // undefined action
        rom[6] = 16'h443C;   // if c0==1: reg0 = 3C
        rom[7] = 16'h08FE;   // jump FE -> 1E

        rst_n = 1'b0; en = 1'b1; c0 = 1'b0; c1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 16'(rom_addr), 16'h0000);
        chk("rst_reg1", 16'(reg1_q), 16'h0000);
        rst_n = 1'b1;
        c1 = 1'b1;

        @(negedge clk);
        chk("e1_reg1", 16'(reg1_q), 16'h0001);
        chk("e1_wr", 16'(reg_wr), 16'h0002);
        chk("e1_addr", 16'(rom_addr), 16'h0001);

        repeat (7) @(negedge clk);
        chk("jmp_addr", 16'(rom_addr), 16'h001E);
        chk("jmp_pulse", 16'(jump_taken), 16'h0001);
        @(negedge clk);
        chk("pre_wrap", 16'(rom_addr), 16'h001F);
        @(negedge clk);
        chk("wrap_addr", 16'(rom_addr), 16'h0000);
        chk("wrap_wr", 16'(reg_wr), 16'h0000);

        repeat (5) @(negedge clk);
        chk("wait_addr", 16'(rom_addr), 16'h0001);
        chk("wait_jump", 16'(jump_taken), 16'h0001);
        c1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_hold", 16'(rom_addr), 16'h0001);
        chk("wait_hold_jump", 16'(jump_taken), 16'h0001);
        @(negedge clk);
        chk("wait_exit", 16'(rom_addr), 16'h0002);
        chk("wait_exit_jump", 16'(jump_taken), 16'h0000);

        @(negedge clk);
        chk("pc3", 16'(rom_addr), 16'h0003);
        en = 1'b0;
        rom[3] = 16'h0799;
        repeat (5) @(negedge clk);
        chk("en_addr", 16'(rom_addr), 16'h0003);
        chk("en_reg3", 16'(reg3_q), 16'h0055);
        chk("en_wr", 16'(reg_wr), 16'h0000);
        en = 1'b1;
        c0 = 1'b1;
        @(negedge clk);
        chk("en_write", 16'(reg3_q), 16'h0099);
        chk("en_write_wr", 16'(reg_wr), 16'h0008);
        chk("en_addr4", 16'(rom_addr), 16'h0004);
        repeat (3) @(negedge clk);
        chk("c0_hi_reg0", 16'(reg0_q), 16'h003C);
        chk("c0_hi_wr", 16'(reg_wr), 16'h0001);
        chk("c0_hi_addr", 16'(rom_addr), 16'h0007);

        repeat (300) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            c0 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        en = 1'b1; c0 = 1'b0; c1 = 1'b0;
        rom[7]  = 16'h080B;
        rom[11] = 16'h0577;
        k = 0;
        while (rom_addr !== 5'h0B && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_0b", 16'(rom_addr), 16'h000B);
        #2 rst_n = 1'b0;
        #1;
        chk("async_addr", 16'(rom_addr), 16'h0000);
        chk("async_reg1", 16'(reg1_q), 16'h0000);
        chk("async_reg3", 16'(reg3_q), 16'h0000);
        chk("async_wr", 16'(reg_wr), 16'h0000);
        chk("async_jump", 16'(jump_taken), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_addr", 16'(rom_addr), 16'(RPC));
        @(negedge clk);
        chk("rel_reg1", 16'(reg1_q), 16'h0001);
        chk("rel_addr1", 16'(rom_addr), 16'h0001);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
